// File: rtl/regbank_sequencer_pkg.sv
// Shared definitions for the DiBU register bank sequencer: read FSM encoding,
// default widths and the bank rw encoding.
package regbank_sequencer_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int IDX_W_DEF  = 3;

   localparam logic RB_READ  = 1'b0;
   localparam logic RB_WRITE = 1'b1;

   typedef logic [1:0] seq_state_t;

   localparam seq_state_t ST_IDLE = 2'd0;
   localparam seq_state_t ST_READ = 2'd1;
   localparam seq_state_t ST_CAPT = 2'd2;
   localparam seq_state_t ST_RESP = 2'd3;

endpackage

// File: rtl/regbank_sequencer_if.sv
// Pipeline and bank-side signals of the register bank sequencer.
// The slave modport is the sequencer; the master modport is its environment.
interface regbank_sequencer_if
   import regbank_sequencer_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int IDX_W  = IDX_W_DEF
) ();

   logic              rd_valid;
   logic              rd_ready;
   logic [IDX_W-1:0]  rd_src_a;
   logic [IDX_W-1:0]  rd_src_b;
   logic              op_valid;
   logic              op_ready;
   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;
   logic              wr_valid;
   logic              wr_ready;
   logic [IDX_W-1:0]  wr_dst;
   logic [DATA_W-1:0] wr_data;
   logic [IDX_W-1:0]  rb_ri_a;
   logic [IDX_W-1:0]  rb_ri_b;
   logic [IDX_W-1:0]  rb_ri_d;
   logic              rb_rw;
   logic [DATA_W-1:0] rb_d;
   logic [DATA_W-1:0] rb_a;
   logic [DATA_W-1:0] rb_b;

   modport master (
      output rd_valid, rd_src_a, rd_src_b, op_ready, wr_valid, wr_dst, wr_data, rb_a, rb_b,
      input  rd_ready, op_valid, op_a, op_b, wr_ready, rb_ri_a, rb_ri_b, rb_ri_d, rb_rw, rb_d
   );

   modport slave (
      input  rd_valid, rd_src_a, rd_src_b, op_ready, wr_valid, wr_dst, wr_data, rb_a, rb_b,
      output rd_ready, op_valid, op_a, op_b, wr_ready, rb_ri_a, rb_ri_b, rb_ri_d, rb_rw, rb_d
   );

endinterface

// File: rtl/regbank_sequencer_arb.sv
// Read/write arbiter for the sequencer: writes normally win in IDLE, but a
// read beats a write that directly follows another write so reads never starve.
module regseq_arb
   import regbank_sequencer_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  seq_state_t state,
   input  logic       rd_valid,
   input  logic       wr_valid,
   output logic       rd_ready,
   output logic       wr_ready
);

   logic last_wr;
   logic in_idle;
   logic conflict;

   always_comb begin
      in_idle  = (state == ST_IDLE);
      conflict = in_idle && rd_valid && wr_valid;
      rd_ready = rst && in_idle && !(conflict && !last_wr);
      wr_ready = rst && !(conflict && last_wr);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         last_wr <= 1'b0;
      else
         last_wr <= wr_valid && wr_ready;
   end

endmodule

// File: rtl/regbank_sequencer.sv
// Initiator for the DiBU main register bank: serialises operand reads and writebacks.
// Define REGSEQ_ZERO_REG_EN to hardwire register 0 to zero.
module regbank_sequencer
   import regbank_sequencer_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int IDX_W  = IDX_W_DEF
) (
   input logic                clk,
   input logic                rst,
   regbank_sequencer_if.slave bus
);

   seq_state_t        state;
   logic              rd_ready_w;
   logic              wr_ready_w;
   logic              rd_fire;
   logic              wr_fire;
   logic              wr_keep;
   logic [DATA_W-1:0] cap_a;
   logic [DATA_W-1:0] cap_b;

   logic [IDX_W-1:0]  ri_a_q;
   logic [IDX_W-1:0]  ri_b_q;
   logic [IDX_W-1:0]  ri_d_q;
   logic              rw_q;
   logic [DATA_W-1:0] d_q;
   logic              op_valid_q;
   logic [DATA_W-1:0] op_a_q;
   logic [DATA_W-1:0] op_b_q;

   regseq_arb u_arb (
      .clk      (clk),
      .rst      (rst),
      .state    (state),
      .rd_valid (bus.rd_valid),
      .wr_valid (bus.wr_valid),
      .rd_ready (rd_ready_w),
      .wr_ready (wr_ready_w)
   );

   // The held read indices double as the zero-register detect at capture time.
   always_comb begin
      rd_fire = bus.rd_valid && rd_ready_w;
      wr_fire = bus.wr_valid && wr_ready_w;
`ifdef REGSEQ_ZERO_REG_EN
      wr_keep = wr_fire && (bus.wr_dst != '0);
      cap_a   = (ri_a_q == '0) ? '0 : bus.rb_a;
      cap_b   = (ri_b_q == '0) ? '0 : bus.rb_b;
`else
      wr_keep = wr_fire;
      cap_a   = bus.rb_a;
      cap_b   = bus.rb_b;
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: if (rd_fire) state <= ST_READ;
            ST_READ: state <= ST_CAPT;
            ST_CAPT: state <= ST_RESP;
            ST_RESP: if (bus.op_ready) state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ri_a_q <= '0;
         ri_b_q <= '0;
      end else if (rd_fire) begin
         ri_a_q <= bus.rd_src_a;
         ri_b_q <= bus.rd_src_b;
      end
   end

   // Write strobe lives for exactly one cycle; index and data simply hold afterwards.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rw_q   <= RB_READ;
         ri_d_q <= '0;
         d_q    <= '0;
      end else begin
         rw_q <= wr_keep ? RB_WRITE : RB_READ;
         if (wr_fire) begin
            ri_d_q <= bus.wr_dst;
            d_q    <= bus.wr_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_valid_q <= 1'b0;
         op_a_q     <= '0;
         op_b_q     <= '0;
      end else if (state == ST_CAPT) begin
         op_valid_q <= 1'b1;
         op_a_q     <= cap_a;
         op_b_q     <= cap_b;
      end else if ((state == ST_RESP) && bus.op_ready) begin
         op_valid_q <= 1'b0;
      end
   end

   assign bus.rd_ready = rd_ready_w;
   assign bus.wr_ready = wr_ready_w;
   assign bus.rb_ri_a  = ri_a_q;
   assign bus.rb_ri_b  = ri_b_q;
   assign bus.rb_ri_d  = ri_d_q;
   assign bus.rb_rw    = rw_q;
   assign bus.rb_d     = d_q;
   assign bus.op_valid = op_valid_q;
   assign bus.op_a     = op_a_q;
   assign bus.op_b     = op_b_q;

endmodule

// File: doc/regbank_sequencer.md
# regbank_sequencer

Initiator side of the DiBU main register bank: accepts operand-read and writeback requests from the pipeline over valid/ready handshakes and drives the bank's index, `rw` and write-data inputs. It captures the bank's registered `a`/`b` read outputs into its own operand registers. It sits between decode/writeback and the bank, serialising the bank's single read-or-write per cycle.

## Interface
- `DATA_W`, default 8, data width; must match the bank.
- `IDX_W`, default 3, register index width (8 registers).
- `clk`  in  1  main clock; all state on posedge.
- `rst`  in  1  asynchronous, active-low reset.
- `rd_valid` / `rd_ready`  in/out  1  operand read request handshake.
- `rd_src_a`, `rd_src_b`  in  IDX_W  source register indices.
- `op_valid` / `op_ready`  out/in  1  operand response handshake.
- `op_a`, `op_b`  out  DATA_W  captured operand values.
- `wr_valid` / `wr_ready`  in/out  1  writeback request handshake.
- `wr_dst`  in  IDX_W  destination index; `wr_data`  in  DATA_W  write value.
- `rb_ri_a`, `rb_ri_b`, `rb_ri_d`  out  IDX_W  to bank index inputs.
- `rb_rw`  out  1  to bank; 0 = read, 1 = write.
- `rb_d`  out  DATA_W  to bank write data.
- `rb_a`, `rb_b`  in  DATA_W  from bank registered read outputs.

## Operation
- Read FSM: IDLE → READ → CAPT → RESP → IDLE.
- IDLE: a read is accepted when `rd_valid && rd_ready`. Sources are latched and the FSM goes to READ.
- READ: drives `rb_rw=0`, `rb_ri_a/b` = latched sources. The bank samples at the end of this cycle.
- CAPT: `rb_a/b` are valid. They are captured into `op_a/op_b` at the end of the cycle.
- RESP: `op_valid=1`, `op_a/op_b` held stable until `op_ready`. Then return to IDLE.
- Writes are independent of the read FSM. On acceptance, `rb_rw=1`, `rb_ri_d=wr_dst` and `rb_d=wr_data` are registered for exactly the next cycle. The bank writes at the end of that cycle.
- `wr_ready=1` in every state except in the IDLE arbitration case below. A write in READ/CAPT/RESP is safe because the bank holds `a/b` while `rb_rw=1`.
- Arbitration, IDLE only, both `rd_valid` and `wr_valid` high:
  - Write wins (`rd_ready=0`).
  - Exception: if the previous cycle also accepted a write (`last_wr` flag), read wins (`wr_ready=0`).
  - Result: reads cannot be starved.
- `rd_ready=0` outside IDLE.
- Ordering: a write accepted before a read is visible to that read (write completes in the cycle before READ at the latest).
- Cycles with no write drive `rb_rw=0`. Idle bank reads are harmless because operands come only from the captured registers.
- Reset (`rst=0`, async):
  - FSM → IDLE; `op_valid=0`, `op_a/op_b=0`, `rb_rw=0`, `rb_ri_*=0`, `rb_d=0`, `last_wr=0`.
  - `rd_ready=0` and `wr_ready=0` while in reset.
  - Any in-flight read or write is dropped.

## Timing
- Read accepted at edge N → READ in cycle N+1 → CAPT N+2 → `op_valid` high from cycle N+3. Latency is 3 cycles.
- Read throughput is at most one per 4 cycles with `op_ready` tied high.
- Write accepted at edge N → `rb_rw=1` during cycle N+1 → bank updated after edge N+2. Sustained one write per cycle.
- All `rb_*` and `op_*` outputs are registered. Ready signals are combinational from state, `rd_valid`, `wr_valid` and `last_wr`.

## Configuration
- `REGSEQ_ZERO_REG_EN` defined: register 0 is hardwired to zero.
  - A write with `wr_dst==0` is accepted normally but `rb_rw` stays 0 (dropped).
  - A read with source index 0 yields `8'h00` in the corresponding `op_*`, regardless of `rb_a/rb_b`.
- Undefined: register 0 is an ordinary register.

## Structure
- Shared package: FSM state encoding (IDLE, READ, CAPT, RESP), `DATA_W`/`IDX_W` defaults, `RB_READ=0`/`RB_WRITE=1` constants.
- One sub-module, `regseq_arb`: the IDLE read/write arbiter owning `last_wr` and producing `rd_ready`/`wr_ready`.

## Test plan
- Write r3=0xA5, then read a=3, b=0 → `op_a=0xA5`, `op_b=0x00`; `op_valid` exactly 3 cycles after read acceptance.
- `rd_valid` and `wr_valid` both high in IDLE for 3 cycles (writes r1=0x11, r2=0x22) → grants are write, read, write. The read of r1 returns 0x11.
- `op_ready=0` for 5 cycles in RESP while writing r3=0x77 → `op_a/op_b` unchanged and `op_valid` stays high. The write lands; a subsequent read of r3 returns 0x77.
- `rst` asserted low during CAPT → all outputs 0 immediately. After release, FSM is in IDLE and no `op_valid` is produced for the aborted read.
- Back-to-back writes r0..r7 = 0x10..0x17 → one `rb_rw=1` cycle each, consecutive. Reads then return the matching values.
- With `REGSEQ_ZERO_REG_EN`: write r0=0xFF → `rb_rw` never 1. Read a=0, b=0 → `op_a=op_b=0x00`.
